// File: rtl/cpu_pkg.sv
// Shared RV32 decode constants and types for the ID/EX issue slice:
// opcodes, ALU select codes, operand/immediate selectors and the ID/EX register layout.
package cpu_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  localparam logic [5:0] ALU_ADD  = 6'b000000;
  localparam logic [5:0] ALU_SLT  = 6'b000010;
  localparam logic [5:0] ALU_SLTU = 6'b000011;
  localparam logic [5:0] ALU_SUB  = 6'b001000;

  typedef enum logic [2:0] {IMM_R, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;
  typedef enum logic [1:0] {A_RS1, A_PC, A_ZERO} op_a_e;
  typedef enum logic [1:0] {B_RS2, B_IMM, B_FOUR} op_b_e;

  typedef struct packed {
    logic [5:0] select;
    op_a_e      a_sel;
    op_b_e      b_sel;
    imm_type_e  imm_type;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       illegal;
  } decode_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] data1;
    logic [31:0] data2;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [5:0]  select;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        illegal;
  } ex_t;

  // Bits [6:0] are the opcode and never contribute to an immediate.
  function automatic logic [31:0] imm_gen(imm_type_e t, logic [31:7] ins);
    logic [31:0] imm;
    imm = '0;
    case (t)
      IMM_I:   imm = {{20{ins[31]}}, ins[31:20]};
      IMM_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   imm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_U:   imm = {ins[31:12], 12'h000};
      IMM_J:   imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/alu_select_decode.sv
// Combinational RV32IM decode: opcode/funct fields to ALU select, operand muxes and
// control bits, with illegal-instruction detection.
module alu_select_decode
  import cpu_pkg::*;
#(
  parameter bit MEXT_EN = 1'b1
) (
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic [4:0] rd,
  output decode_t    dec
);

  logic wb, ld, st, br, jp, ill;

  always_comb begin
    dec.select   = ALU_ADD;
    dec.a_sel    = A_RS1;
    dec.b_sel    = B_RS2;
    dec.imm_type = IMM_R;
    wb  = 1'b0;
    ld  = 1'b0;
    st  = 1'b0;
    br  = 1'b0;
    jp  = 1'b0;
    ill = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec.select = {1'b0, funct7[0], funct7[5], funct3};
        wb  = 1'b1;
        ill = !((funct7 == F7_BASE) ||
                (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)) ||
                (funct7 == F7_MEXT && MEXT_EN));
      end
      OPC_OP_IMM: begin
        dec.b_sel    = B_IMM;
        dec.imm_type = IMM_I;
        wb = 1'b1;
        // Only the shift-immediates reuse the upper imm bits as funct7.
        if (funct3 == 3'b001) begin
          dec.select = {3'b000, funct3};
          ill = (funct7 != F7_BASE);
        end else if (funct3 == 3'b101) begin
          dec.select = {2'b00, funct7[5], funct3};
          ill = !(funct7 == F7_BASE || funct7 == F7_ALT);
        end else begin
          dec.select = {3'b000, funct3};
        end
      end
      OPC_LOAD: begin
        dec.b_sel    = B_IMM;
        dec.imm_type = IMM_I;
        wb = 1'b1;
        ld = 1'b1;
      end
      OPC_STORE: begin
        dec.b_sel    = B_IMM;
        dec.imm_type = IMM_S;
        st = 1'b1;
      end
      OPC_LUI: begin
        dec.a_sel    = A_ZERO;
        dec.b_sel    = B_IMM;
        dec.imm_type = IMM_U;
        wb = 1'b1;
      end
      OPC_AUIPC: begin
        dec.a_sel    = A_PC;
        dec.b_sel    = B_IMM;
        dec.imm_type = IMM_U;
        wb = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        dec.a_sel    = A_PC;
        dec.b_sel    = B_FOUR;
        dec.imm_type = (opcode == OPC_JAL) ? IMM_J : IMM_I;
        wb = 1'b1;
        jp = 1'b1;
      end
      OPC_BRANCH: begin
        dec.imm_type = IMM_B;
        br = 1'b1;
        if (funct3[2]) dec.select = funct3[1] ? ALU_SLTU : ALU_SLT;
        else           dec.select = ALU_SUB;
      end
      default: ill = 1'b1;
    endcase
    dec.illegal   = ill;
    dec.reg_write = wb && (rd != 5'd0) && !ill;
    dec.mem_read  = ld && !ill;
    dec.mem_write = st && !ill;
    dec.branch    = br && !ill;
    dec.jump      = jp && !ill;
  end

endmodule

// File: rtl/id_ex_alu_issue.sv
// ID/EX issue stage: decodes one instruction per cycle, builds ALU operands and select,
// and holds them in the ID/EX register with stall (hold) and flush (bubble).
module id_ex_alu_issue
  import cpu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit MEXT_EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic            stall,
  input  logic            flush,
  output logic            out_valid,
  output logic [XLEN-1:0] data1,
  output logic [XLEN-1:0] data2,
  output logic [5:0]      select,
  output logic [XLEN-1:0] out_rs2,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rd,
  output logic            out_reg_write,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic            out_branch,
  output logic            out_jump,
  output logic [2:0]      out_funct3,
  output logic            out_illegal
);

  decode_t     dec;
  logic [31:0] imm;
  logic [31:0] op_a;
  logic [31:0] op_b;
  ex_t         ex_reg;
  ex_t         ex_next;

  alu_select_decode #(.MEXT_EN(MEXT_EN)) u_decode (
    .opcode (in_instr[6:0]),
    .funct3 (in_instr[14:12]),
    .funct7 (in_instr[31:25]),
    .rd     (in_instr[11:7]),
    .dec    (dec)
  );

  always_comb begin
    imm = imm_gen(dec.imm_type, in_instr[31:7]);
    case (dec.a_sel)
      A_RS1:   op_a = in_rs1_data;
      A_PC:    op_a = in_pc;
      default: op_a = '0;
    endcase
    case (dec.b_sel)
      B_RS2:   op_b = in_rs2_data;
      B_IMM:   op_b = imm;
      B_FOUR:  op_b = 32'd4;
      default: op_b = '0;
    endcase
  end

  // Flush outranks stall; on a bubble only valid and control bits are cleared.
  always_comb begin
    ex_next = ex_reg;
    if (flush) begin
      ex_next.valid     = 1'b0;
      ex_next.reg_write = 1'b0;
      ex_next.mem_read  = 1'b0;
      ex_next.mem_write = 1'b0;
      ex_next.branch    = 1'b0;
      ex_next.jump      = 1'b0;
      ex_next.illegal   = 1'b0;
    end else if (!stall) begin
      ex_next.valid     = in_valid;
      ex_next.data1     = op_a;
      ex_next.data2     = op_b;
      ex_next.rs2       = in_rs2_data;
      ex_next.imm       = imm;
      ex_next.pc        = in_pc;
      ex_next.select    = dec.select;
      ex_next.rd        = in_instr[11:7];
      ex_next.funct3    = in_instr[14:12];
      ex_next.reg_write = in_valid && dec.reg_write;
      ex_next.mem_read  = in_valid && dec.mem_read;
      ex_next.mem_write = in_valid && dec.mem_write;
      ex_next.branch    = in_valid && dec.branch;
      ex_next.jump      = in_valid && dec.jump;
      ex_next.illegal   = in_valid && dec.illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) ex_reg <= '0;
    else        ex_reg <= ex_next;
  end

  assign out_valid     = ex_reg.valid;
  assign data1         = ex_reg.data1;
  assign data2         = ex_reg.data2;
  assign select        = ex_reg.select;
  assign out_rs2       = ex_reg.rs2;
  assign out_imm       = ex_reg.imm;
  assign out_pc        = ex_reg.pc;
  assign out_rd        = ex_reg.rd;
  assign out_reg_write = ex_reg.reg_write;
  assign out_mem_read  = ex_reg.mem_read;
  assign out_mem_write = ex_reg.mem_write;
  assign out_branch    = ex_reg.branch;
  assign out_jump      = ex_reg.jump;
  assign out_funct3    = ex_reg.funct3;
  assign out_illegal   = ex_reg.illegal;

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Scoreboard bench for id_ex_alu_issue: two instances (M extension off/on) driven in
// parallel, checked against an instruction-level reference model.
module tb_id_ex_alu_issue;

  typedef struct packed {
    logic        valid, illegal, rw, mr, mw, br, jp, chk;
    logic [31:0] d1, d2, rs2, imm, pc;
    logic [5:0]  sel;
    logic [4:0]  rd;
    logic [2:0]  f3;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, in_valid, stall, flush;
  logic [31:0] in_instr, in_pc, in_rs1_data, in_rs2_data;

  logic        valid_o [2], illegal_o [2], rw_o [2], mr_o [2], mw_o [2], br_o [2], jp_o [2];
  logic [31:0] d1_o [2], d2_o [2], rs2_o [2], imm_o [2], pc_o [2];
  logic [5:0]  sel_o [2];
  logic [4:0]  rd_o [2];
  logic [2:0]  f3_o [2];

  // Index 0: MEXT_EN=0, index 1: MEXT_EN=1
  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    id_ex_alu_issue #(.XLEN(32), .MEXT_EN(gi == 1)) u_dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
      .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .stall(stall), .flush(flush),
      .out_valid(valid_o[gi]), .data1(d1_o[gi]), .data2(d2_o[gi]), .select(sel_o[gi]),
      .out_rs2(rs2_o[gi]), .out_imm(imm_o[gi]), .out_pc(pc_o[gi]), .out_rd(rd_o[gi]),
      .out_reg_write(rw_o[gi]), .out_mem_read(mr_o[gi]), .out_mem_write(mw_o[gi]),
      .out_branch(br_o[gi]), .out_jump(jp_o[gi]), .out_funct3(f3_o[gi]),
      .out_illegal(illegal_o[gi])
    );
  end

  int   n_chk = 0;
  int   n_fail = 0;
  exp_t q0 [$];
  exp_t q1 [$];
  exp_t m0, m1;

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // What the EX slot should present for one instruction, from the ISA rules.
  function automatic exp_t ref_decode(logic [31:0] ins, logic [31:0] pc, logic [31:0] a,
                                      logic [31:0] b, bit mext);
    exp_t e;
    logic [6:0] f7;
    logic [2:0] f3;
    logic signed [31:0] ii, si, bi, ji;
    logic [31:0] ui;
    bit legal;
    f7 = ins[31:25];
    f3 = ins[14:12];
    ii = $signed(ins[31:20]);
    si = $signed({ins[31:25], ins[11:7]});
    bi = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
    ji = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
    ui = {ins[31:12], 12'h000};
    e = '0;
    e.valid = 1'b1; e.chk = 1'b1; e.pc = pc; e.rs2 = b; e.rd = ins[11:7]; e.f3 = f3;
    legal = 1'b1;
    case (ins[6:0])
      7'h33: begin
        legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) ||
                (f7 == 7'h01 && mext);
        e.d1 = a; e.d2 = b; e.sel = {1'b0, f7[0], f7[5], f3}; e.rw = 1'b1;
      end
      7'h13: begin
        e.d1 = a; e.d2 = ii; e.imm = ii; e.rw = 1'b1; e.sel = {3'b000, f3};
        if (f3 == 3'd1) legal = (f7 == 7'h00);
        if (f3 == 3'd5) begin
          legal = (f7 == 7'h00 || f7 == 7'h20);
          e.sel = {2'b00, f7[5], f3};
        end
      end
      7'h03: begin e.d1 = a;  e.d2 = ii;    e.imm = ii; e.mr = 1'b1; e.rw = 1'b1; end
      7'h23: begin e.d1 = a;  e.d2 = si;    e.imm = si; e.mw = 1'b1; end
      7'h37: begin e.d1 = 0;  e.d2 = ui;    e.imm = ui; e.rw = 1'b1; end
      7'h17: begin e.d1 = pc; e.d2 = ui;    e.imm = ui; e.rw = 1'b1; end
      7'h6F: begin e.d1 = pc; e.d2 = 32'd4; e.imm = ji; e.jp = 1'b1; e.rw = 1'b1; end
      7'h67: begin e.d1 = pc; e.d2 = 32'd4; e.imm = ii; e.jp = 1'b1; e.rw = 1'b1; end
      7'h63: begin
        e.d1 = a; e.d2 = b; e.imm = bi; e.br = 1'b1;
        if (f3 == 3'd0 || f3 == 3'd1)      e.sel = 6'b001000;
        else if (f3 == 3'd4 || f3 == 3'd5) e.sel = 6'b000010;
        else                               e.sel = 6'b000011;
      end
      default: legal = 1'b0;
    endcase
    if (e.rd == 5'd0) e.rw = 1'b0;
    if (!legal) begin
      e.illegal = 1'b1; e.chk = 1'b0;
      e.rw = 1'b0; e.mr = 1'b0; e.mw = 1'b0; e.br = 1'b0; e.jp = 1'b0;
    end
    return e;
  endfunction

  function automatic exp_t bubble(exp_t cur);
    exp_t n = cur;
    n.valid = 1'b0; n.illegal = 1'b0; n.rw = 1'b0; n.mr = 1'b0;
    n.mw = 1'b0; n.br = 1'b0; n.jp = 1'b0; n.chk = 1'b0;
    return n;
  endfunction

  function automatic exp_t advance(exp_t cur, bit rn, bit v, bit st, bit fl, exp_t cap);
    exp_t n = cur;
    if (!rn) begin
      n = '0;
      n.chk = 1'b1;
    end else if (fl) n = bubble(cur);
    else if (!st)    n = v ? cap : bubble(cur);
    return n;
  endfunction

  task automatic step(bit rn, bit v, logic [31:0] ins, logic [31:0] pc, logic [31:0] a,
                      logic [31:0] b, bit st, bit fl);
    @(negedge clk);
    reset = rn; in_valid = v; in_instr = ins; in_pc = pc;
    in_rs1_data = a; in_rs2_data = b; stall = st; flush = fl;
    m0 = advance(m0, rn, v, st, fl, ref_decode(ins, pc, a, b, 1'b0));
    m1 = advance(m1, rn, v, st, fl, ref_decode(ins, pc, a, b, 1'b1));
    q0.push_back(m0);
    q1.push_back(m1);
  endtask

  task automatic check_one(int k, exp_t e);
    string p;
    p = $sformatf("m%0d.", k);
    chk({p, "valid"},   valid_o[k],   e.valid);
    chk({p, "illegal"}, illegal_o[k], e.illegal);
    chk({p, "reg_wr"},  rw_o[k],      e.rw);
    chk({p, "mem_rd"},  mr_o[k],      e.mr);
    chk({p, "mem_wr"},  mw_o[k],      e.mw);
    chk({p, "branch"},  br_o[k],      e.br);
    chk({p, "jump"},    jp_o[k],      e.jp);
    if (e.chk) begin
      chk({p, "data1"},  d1_o[k],  e.d1);
      chk({p, "data2"},  d2_o[k],  e.d2);
      chk({p, "select"}, sel_o[k], e.sel);
      chk({p, "rs2"},    rs2_o[k], e.rs2);
      chk({p, "imm"},    imm_o[k], e.imm);
      chk({p, "pc"},     pc_o[k],  e.pc);
      chk({p, "rd"},     rd_o[k],  e.rd);
      chk({p, "funct3"}, f3_o[k],  e.f3);
    end
    $display("txn m%0d valid=%0b ill=%0b sel=%b d1=%h d2=%h", k, valid_o[k], illegal_o[k],
             sel_o[k], d1_o[k], d2_o[k]);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) check_one(0, q0.pop_front());
      if (q1.size() > 0) check_one(1, q1.pop_front());
    end
  end

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int unsigned f;
    w = $urandom;
    case ($urandom_range(0, 10))
      0, 1: begin
        w[6:0] = 7'h33;
        case ($urandom_range(0, 3))
          0: w[31:25] = 7'h00;
          1: w[31:25] = 7'h20;
          2: w[31:25] = 7'h01;
          default: ;
        endcase
      end
      2, 3: begin
        w[6:0] = 7'h13;
        if (w[14:12] == 3'd1 || w[14:12] == 3'd5) begin
          case ($urandom_range(0, 2))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            default: ;
          endcase
        end
      end
      4: w[6:0] = 7'h03;
      5: w[6:0] = 7'h23;
      6: w[6:0] = ($urandom_range(0, 1) != 0) ? 7'h37 : 7'h17;
      7: w[6:0] = ($urandom_range(0, 1) != 0) ? 7'h6F : 7'h67;
      8: begin
        w[6:0] = 7'h63;
        f = $urandom_range(0, 5);
        w[14:12] = 3'((f < 2) ? f : f + 2);
      end
      default: begin
        case ($urandom_range(0, 3))
          0: w[6:0] = 7'h73;
          1: w[6:0] = 7'h0F;
          2: w[6:0] = 7'h7F;
          default: w[6:0] = 7'h00;
        endcase
      end
    endcase
    return w;
  endfunction

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    in_rs1_data = '0; in_rs2_data = '0; stall = 1'b0; flush = 1'b0;
    m0 = '0; m1 = '0;

    repeat (2) step(1'b0, 1'b1, $urandom, $urandom, $urandom, $urandom,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    step(1'b1, 1'b1, 32'hFFD08293, 32'h0, 32'd10, 32'h55, 1'b0, 1'b0);
    @(posedge clk); #2;
    chk("addi_data1", d1_o[1], 32'd10);
    chk("addi_data2", d2_o[1], 32'hFFFFFFFD);
    chk("addi_select", sel_o[1], 6'b000000);
    chk("addi_rd", rd_o[1], 5'd5);
    chk("addi_regwr", rw_o[1], 1'b1);

    step(1'b1, 1'b1, 32'h022081B3, 32'h4, 32'd7, 32'd6, 1'b0, 1'b0);
    @(posedge clk); #2;
    chk("mul_select", sel_o[1], 6'b010000);
    chk("mul_nom_illegal", illegal_o[0], 1'b1);
    chk("mul_nom_valid", valid_o[0], 1'b1);
    chk("mul_nom_regwr", rw_o[0], 1'b0);

    step(1'b1, 1'b1, 32'h12345097, 32'h100, 32'h1, 32'h2, 1'b0, 1'b0);
    @(posedge clk); #2;
    chk("auipc_data1", d1_o[1], 32'h100);
    chk("auipc_data2", d2_o[1], 32'h12345000);

    step(1'b1, 1'b1, 32'h0020E463, 32'h104, 32'h3, 32'h9, 1'b0, 1'b0);
    @(posedge clk); #2;
    chk("bltu_select", sel_o[1], 6'b000011);
    chk("bltu_branch", br_o[1], 1'b1);
    chk("bltu_imm", imm_o[1], 32'd8);

    step(1'b1, 1'b1, 32'hFFD08293, 32'h108, 32'd10, 32'h0, 1'b0, 1'b0);
    repeat (3) step(1'b1, 1'b1, rand_instr(), $urandom, $urandom, $urandom, 1'b1, 1'b0);
    @(posedge clk); #2;
    chk("stall_hold_data2", d2_o[1], 32'hFFFFFFFD);

    step(1'b1, 1'b1, rand_instr(), $urandom, $urandom, $urandom, 1'b1, 1'b1);
    @(posedge clk); #2;
    chk("stall_flush_valid", valid_o[1], 1'b0);

    step(1'b1, 1'b1, 32'h00100013, 32'h200, 32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #2;
    chk("x0_regwr", rw_o[1], 1'b0);
    chk("x0_valid", valid_o[1], 1'b1);

    step(1'b1, 1'b1, 32'hFFD08293, 32'h204, 32'd10, 32'h0, 1'b0, 1'b0);
    step(1'b0, 1'b1, rand_instr(), $urandom, $urandom, $urandom, 1'b1, 1'b0);
    @(posedge clk); #2;
    chk("rst_stall_valid", valid_o[1], 1'b0);
    chk("rst_stall_data1", d1_o[1], 32'h0);

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 49) != 0, $urandom_range(0, 7) != 0, rand_instr(),
           $urandom, $urandom, $urandom,
           $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
    end

    @(posedge clk); #3;
    chk("scoreboard_drained", 32'(q0.size() + q1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
